// File: rtl/imm_ext_arbiter.sv
// imm_ext_arbiter
// Two requesters share one immediate-extension unit and one output register.
// Round-robin arbitration picks a requester; the accepted request is extended
// in the same cycle and held in the output register until the consumer takes it.
// The output stage is a two-state EMPTY/FULL buffer that allows one result per
// cycle when the consumer is always ready.

module imm_ext_arbiter #(
  parameter int LUI_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_mode,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_mode,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src,
  output logic        out_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_grant;
  logic        grant;
  logic        any_valid;
  logic        can_accept;
  logic        accept;
  logic [15:0] sel_imm;
  logic [1:0]  sel_mode;
  logic [31:0] ext_data;
  logic        ext_err;

  // Round-robin choice: a lone requester wins; on contention the one not served last time wins
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign any_valid  = req0_valid | req1_valid;
  assign can_accept = (state == EMPTY) || out_ready;

  // Readies are held low during reset and whenever nobody is asking
  assign req0_ready = rst_n & can_accept & any_valid & ~grant;
  assign req1_ready = rst_n & can_accept & any_valid &  grant;

  assign accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);

  // Steer the granted requester's immediate and mode into the shared extender
  always_comb begin
    sel_imm  = req0_imm;
    sel_mode = req0_mode;
    if (grant) begin
      sel_imm  = req1_imm;
      sel_mode = req1_mode;
    end
  end

  // Extension unit: sign, zero, load-upper; reserved modes yield zero with error
  always_comb begin
    ext_data = 32'h0000_0000;
    ext_err  = 1'b0;
    case (sel_mode)
      2'b00: ext_data = {{16{sel_imm[15]}}, sel_imm};
      2'b01: ext_data = {16'h0000, sel_imm};
      2'b10: begin
        if (LUI_EN != 0) begin
          ext_data = {sel_imm, 16'h0000};
        end else begin
          ext_err = 1'b1;
        end
      end
      default: ext_err = 1'b1;
    endcase
  end

  // State register for the output buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: fill on accept, drain when consumed without a refill
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_ready && !accept) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  assign out_valid = (state == FULL);

  // Output register loads only on an accepted transfer, otherwise holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= 32'h0000_0000;
      out_src  <= 1'b0;
      out_err  <= 1'b0;
    end else if (accept) begin
      out_data <= ext_data;
      out_src  <= grant;
      out_err  <= ext_err;
    end
  end

  // Last-grant pointer moves only on accepted transfers; starts at 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: doc/imm_ext_arbiter.md
IMM_EXT_ARBITER -- requirements
Module: imm_ext_arbiter

Interface
REQ-001 Parameter LUI_EN, default 1, meaning: 1 enables load-upper mode (mode 2'b10); 0 treats mode 2'b10 as reserved.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 req0_valid  input  1  requester 0 (decode stage) presents an immediate.
REQ-005 req0_imm  input  16  requester 0 raw 16-bit immediate.
REQ-006 req0_mode  input  2  requester 0 extension mode: 00 sign, 01 zero, 10 load-upper, 11 reserved.
REQ-007 req0_ready  output  1  requester 0 request accepted this cycle when high with req0_valid.
REQ-008 req1_valid  input  1  requester 1 (branch-target path) presents an immediate.
REQ-009 req1_imm  input  16  requester 1 raw 16-bit immediate.
REQ-010 req1_mode  input  2  requester 1 extension mode, same encoding as req0_mode.
REQ-011 req1_ready  output  1  requester 1 request accepted this cycle when high with req1_valid.
REQ-012 out_valid  output  1  out_data/out_src/out_err hold a result.
REQ-013 out_ready  input  1  consumer takes the result this cycle when high with out_valid.
REQ-014 out_data  output  32  extended immediate.
REQ-015 out_src  output  1  index of the requester that produced out_data.
REQ-016 out_err  output  1  result came from a reserved mode.

Function
REQ-017 Block SHALL share a single extension unit and one output register between two requesters, with a two-state FSM: EMPTY (no result held) and FULL (result held).
REQ-018 can_accept SHALL equal (state==EMPTY) or (state==FULL and out_ready); reqN_ready SHALL be combinational: can_accept and grant==N.
REQ-019 Arbitration SHALL be round-robin: with one requester valid, it is granted; with both valid, the requester not granted at the last accept is granted; with none valid, grant is don't-care and both readies are 0.
REQ-020 The last-grant pointer SHALL update only on an accepted transfer (reqN_valid and reqN_ready), never on stalled cycles.
REQ-021 Latency SHALL be one cycle: request accepted at edge N -> out_valid=1 with its result after edge N.
REQ-022 Mode 00 SHALL produce {16{imm[15]},imm}; mode 01 SHALL produce {16'h0000,imm}; mode 10 (LUI_EN=1) SHALL produce {imm,16'h0000}.
REQ-023 Mode 11, or mode 10 with LUI_EN=0, SHALL produce out_data=32'h0000_0000 and out_err=1; all other modes SHALL produce out_err=0.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_src and out_err SHALL remain stable and both readies SHALL be 0.
REQ-025 FSM transitions: EMPTY->FULL on accept; FULL->EMPTY on out_ready with no accept; FULL->FULL (register reloaded) on out_ready with simultaneous accept, giving back-to-back throughput of one result per cycle.
REQ-026 Every output SHALL be fully defined in every cycle; no latch inference; the extension SHALL be computed from the granted request's imm/mode in the same cycle it is accepted.
REQ-027 Inputs of a non-granted requester SHALL not affect out_data; a requester may drop reqN_valid without penalty when not accepted.

Reset
REQ-028 Reset=0 SHALL asynchronously force state=EMPTY, out_valid=0, out_data=32'h0, out_src=0, out_err=0, and the last-grant pointer to 1 (so requester 0 wins the first contention).
REQ-029 Reset asserted while FULL SHALL discard the held result; no result SHALL appear after Reset deasserts until a new accept.
REQ-030 req0_ready and req1_ready SHALL be 0 while Reset=0.

Verification
REQ-031 Reset released, req0 imm=16'h8001 mode=00, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF_8001, out_src=0, out_err=0.
REQ-032 Both valid every cycle (req0 imm=16'h00FF mode=01, req1 imm=16'h1234 mode=10), out_ready=1 -> results alternate src 0,1,0,...: 32'h0000_00FF, 32'h1234_0000, one per cycle.
REQ-033 Hold out_ready=0 for 3 cycles after one accept with both requesters valid -> out_data frozen, both readies 0; on out_ready=1 the other requester is granted in the same cycle.
REQ-034 req1 mode=11 imm=16'hABCD, then LUI_EN=0 instance with mode=10 -> out_data=32'h0, out_err=1 in both cases.
REQ-035 Reset pulsed low asynchronously mid-cycle while FULL -> out_valid drops immediately; after release, first contention grants req0.
